// File: rtl/queue_read_ctrl.sv
// Consumer side of the pointer-pair queue: issues 1-cycle memory reads and presents each word on a registered valid/ready port.
// Latency: RdEn in the cycle Empty falls, DataValid two edges later; DataOut is held while DataValid && !RdReady.
module queue_read_ctrl #(
  parameter int numOfBit  = 11,
  parameter int dataWidth = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [numOfBit:0]    WrPtr,
  input  logic [dataWidth-1:0] MemData,
  input  logic                 RdReady,
  output logic                 RdEn,
  output logic [numOfBit-1:0]  RdAddr,
  output logic [numOfBit:0]    RdPtr,
  output logic [dataWidth-1:0] DataOut,
  output logic                 DataValid,
  output logic                 Empty,
  output logic [numOfBit:0]    Count
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [numOfBit:0]    r_rd_ptr;
  logic [dataWidth-1:0] r_data;
  logic                 r_data_vld;
  logic                 w_empty;
  logic                 w_can_read;
  logic                 w_rd_en;

  // Full-width compare: equal low bits with differing wrap bits means full.
  assign w_empty    = (r_rd_ptr == WrPtr);
  assign w_can_read = Reset && Enable && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_read) begin
          w_rd_en     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_state_nxt = VALID;
      end
      VALID: begin
        if (RdReady) begin
          if (w_can_read) begin
            w_rd_en     = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + {{numOfBit{1'b0}}, 1'b1};
      end
      if (r_state == FETCH) begin
        r_data     <= MemData;
        r_data_vld <= 1'b1;
      end else if ((r_state == VALID) && RdReady) begin
        r_data_vld <= 1'b0;
      end
    end
  end

  assign RdEn      = w_rd_en;
  assign RdAddr    = r_rd_ptr[numOfBit-1:0];
  assign RdPtr     = r_rd_ptr;
  assign DataOut   = r_data;
  assign DataValid = r_data_vld;
  assign Empty     = w_empty;
  assign Count     = WrPtr - r_rd_ptr;

endmodule

// File: tb/tb_queue_read_ctrl.sv
// Bench for queue_read_ctrl at depth 8: words written into a memory model are pushed to a scoreboard and popped on each output handshake.
module tb_queue_read_ctrl;

  logic       CLK;
  logic       Reset;
  logic       Enable;
  logic [3:0] WrPtr;
  logic [7:0] MemData;
  logic       RdReady;
  logic       RdEn;
  logic [2:0] RdAddr;
  logic [3:0] RdPtr;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       Empty;
  logic [3:0] Count;

  logic [7:0] mem [0:7];
  logic [7:0] sb [$];
  logic [3:0] m_rd;
  int         n_checks;
  int         n_fail;

  queue_read_ctrl #(.numOfBit(3), .dataWidth(8)) dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .WrPtr(WrPtr), .MemData(MemData),
    .RdReady(RdReady), .RdEn(RdEn), .RdAddr(RdAddr), .RdPtr(RdPtr), .DataOut(DataOut),
    .DataValid(DataValid), .Empty(Empty), .Count(Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous memory with one-cycle read latency.
  always @(posedge CLK) if (RdEn) MemData <= mem[RdAddr];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Reads must walk the model pointer in order and never hit an empty queue.
  always @(negedge CLK) begin
    if (!Reset) begin
      m_rd = 4'd0;
    end else begin
      if (RdEn) begin
        check_eq("rd_addr", 32'(RdAddr), 32'(m_rd[2:0]));
        check_eq("rd_when_empty", 32'(Empty), 0);
        m_rd = m_rd + 4'd1;
      end
      if (DataValid && RdReady) begin
        check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check_eq("data_out", 32'(DataOut), 32'(sb.pop_front()));
      end
    end
  end

  task automatic write_word(input logic [7:0] d);
    mem[WrPtr[2:0]] = d;
    sb.push_back(d);
    WrPtr = WrPtr + 4'd1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    int  k;
    logic done;
    k    = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      @(negedge CLK);
      done = (sb.size() == 0) && !DataValid;
      k++;
    end
    check_eq(tag, 32'(done), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!DataValid && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check_eq(tag, 32'(DataValid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    Enable   = 1'b0;
    WrPtr    = 4'd0;
    RdReady  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (2) @(negedge CLK);
    check_eq("rst_rdptr", 32'(RdPtr), 0);
    check_eq("rst_valid", 32'(DataValid), 0);
    check_eq("rst_dout", 32'(DataOut), 0);
    check_eq("rst_rden", 32'(RdEn), 0);
    check_eq("rst_empty", 32'(Empty), 1);
    check_eq("rst_count", 32'(Count), 0);

    // Single word: RdEn the cycle Empty falls, valid two edges later.
    step();
    Reset   = 1'b1;
    Enable  = 1'b1;
    RdReady = 1'b1;
    write_word(8'h3C);
    @(negedge CLK);
    check_eq("t1_empty", 32'(Empty), 0);
    check_eq("t1_rden", 32'(RdEn), 1);
    @(negedge CLK);
    check_eq("t1_fetch_valid", 32'(DataValid), 0);
    @(negedge CLK);
    check_eq("t1_valid", 32'(DataValid), 1);
    check_eq("t1_dout", 32'(DataOut), 32'h3C);
    @(negedge CLK);
    check_eq("t1_empty_after", 32'(Empty), 1);
    check_eq("t1_count_after", 32'(Count), 0);
    check_eq("t1_valid_after", 32'(DataValid), 0);

    // Backpressure: first word held for 5 cycles, pop re-issues a read at once.
    step();
    RdReady = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    wait_valid("t2_wait_valid");
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_valid", 32'(DataValid), 1);
      check_eq("t2_hold_dout", 32'(DataOut), 32'h11);
      check_eq("t2_hold_rden", 32'(RdEn), 0);
      @(negedge CLK);
    end
    step();
    RdReady = 1'b1;
    @(negedge CLK);
    check_eq("t2_pop_rden", 32'(RdEn), 1);
    drain("t2_drain");

    // Asynchronous reset while a word is held.
    step();
    RdReady = 1'b0;
    write_word(8'hA5);
    wait_valid("t3_wait_valid");
    check_eq("t3_dout_before", 32'(DataOut), 32'hA5);
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("t3_valid_rst", 32'(DataValid), 0);
    check_eq("t3_dout_rst", 32'(DataOut), 0);
    check_eq("t3_rdptr_rst", 32'(RdPtr), 0);

    // Wrap: full queue drains through addresses 0..7 and the next read lands at 0.
    Enable = 1'b0;
    WrPtr  = 4'd0;
    sb.delete();
    for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
    @(negedge CLK);
    step();
    Reset = 1'b1;
    @(negedge CLK);
    check_eq("t4_full_empty", 32'(Empty), 0);
    check_eq("t4_full_count", 32'(Count), 8);
    check_eq("t4_full_rden", 32'(RdEn), 0);
    step();
    Enable  = 1'b1;
    RdReady = 1'b1;
    drain("t4_drain");
    check_eq("t4_rdptr_wrap", 32'(RdPtr), 8);
    check_eq("t4_empty_wrap", 32'(Empty), 1);
    step();
    write_word(8'h5A);
    drain("t4_drain_next");
    check_eq("t4_rdptr_next", 32'(RdPtr), 9);

    // Enable low holds off reads; reads resume at address 0.
    step();
    Reset  = 1'b0;
    Enable = 1'b0;
    WrPtr  = 4'd0;
    sb.delete();
    for (int i = 0; i < 4; i++) write_word(8'h41 + 8'(i));
    @(negedge CLK);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("t5_no_rden", 32'(RdEn), 0);
      check_eq("t5_count", 32'(Count), 4);
    end
    step();
    Enable = 1'b1;
    drain("t5_drain");
    check_eq("t5_rdptr", 32'(RdPtr), 4);

    // Empty guard at RdPtr == WrPtr == 5.
    step();
    write_word(8'h77);
    drain("t6_drain");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_eq("t6_no_rden", 32'(RdEn), 0);
      check_eq("t6_no_valid", 32'(DataValid), 0);
    end
    check_eq("t6_rdptr", 32'(RdPtr), 5);
    check_eq("t6_empty", 32'(Empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
